// File: rtl/ss_window_decoder_if.sv
// ss_window_decoder_if: stream-in / result-out bundle for ss_window_decoder (master = producer side, slave = decoder)
interface ss_window_decoder_if #(
  parameter int WIN_LOG2 = 8
);
  logic                START;
  logic                EN;
  logic                IN;
  logic                SIGN_IN;
  logic                BUSY;
  logic                VALID;
  logic [WIN_LOG2+1:0] VALUE;
  modport master (output START, EN, IN, SIGN_IN, input BUSY, VALUE, VALID);
  modport slave  (input START, EN, IN, SIGN_IN, output BUSY, VALUE, VALID);
endinterface

// File: rtl/ss_window_decoder.sv
// ss_window_decoder: integrates a sign-magnitude stochastic stream over 2^WIN_LOG2 enabled samples into a signed VALUE with a VALID strobe; ports CLK, INIT (sync reset), bus (START/EN/IN/SIGN_IN in, BUSY/VALUE/VALID out)
module ss_window_decoder #(
  parameter int WIN_LOG2   = 8,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic                 CLK,
  input logic                 INIT,
  ss_window_decoder_if.slave  bus
);
  localparam int W = WIN_LOG2 + 2;
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state_q, state_d;
  logic signed [W-1:0]   acc_q, acc_d, acc_n, value_q, value_d;
  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic                  valid_q, valid_d, last, run;
  always_comb begin
    run     = state_q == RUN;
    last    = run && bus.EN && cnt_q == '1;
    acc_n   = !bus.IN ? acc_q : bus.SIGN_IN ? acc_q - W'(1) : acc_q + W'(1);
    state_d = !run ? ((CONTINUOUS || bus.START) ? RUN : IDLE) : ((last && !CONTINUOUS) ? IDLE : RUN);
    acc_d   = (!run || last) ? '0 : bus.EN ? acc_n : acc_q;
    cnt_d   = !run ? '0 : cnt_q + WIN_LOG2'(bus.EN);
    valid_d = last;
    value_d = last ? acc_n : value_q;
  end
  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end
  assign bus.BUSY  = state_q == RUN;
  assign bus.VALUE = value_q;
  assign bus.VALID = valid_q;
endmodule

// File: tb/tb_ss_window_decoder.sv
// tb_ss_window_decoder: directed scoreboard bench for ss_window_decoder (one-shot and continuous instances, WIN_LOG2=4)
module tb_ss_window_decoder;
  typedef struct {
    logic signed [5:0] v;
    int                c;
  } exp_t;
  logic CLK = 1'b0;
  logic init0, init1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  ss_window_decoder_if #(.WIN_LOG2(4)) b0 ();
  ss_window_decoder_if #(.WIN_LOG2(4)) b1 ();
  ss_window_decoder #(.WIN_LOG2(4), .CONTINUOUS(1'b0)) dut0 (.CLK(CLK), .INIT(init0), .bus(b0));
  ss_window_decoder #(.WIN_LOG2(4), .CONTINUOUS(1'b1)) dut1 (.CLK(CLK), .INIT(init1), .bus(b1));
  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  always @(negedge CLK) begin
    if (b0.VALID === 1'b1) begin
      if (q0.size() == 0) chk("dut0_unexpected_valid", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("dut0_value", int'($signed(b0.VALUE)), int'(e0.v));
        chk("dut0_valid_cycle", cyc, e0.c);
        chk("dut0_busy_at_valid", int'(b0.BUSY), 0);
      end
    end
  end
  always @(negedge CLK) begin
    if (b1.VALID === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_valid", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("dut1_value", int'($signed(b1.VALUE)), int'(e1.v));
        chk("dut1_valid_cycle", cyc, e1.c);
        chk("dut1_busy_at_valid", int'(b1.BUSY), 1);
      end
    end
  end
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic start_win();
    b0.START = 1'b1;
    b0.EN    = 1'b0;
    step();
    b0.START = 1'b0;
  endtask
  task automatic win(input logic [15:0] ins, input logic [15:0] sg, input int ev, input bit stall, input int start_at);
    for (int i = 0; i < 16; i++) begin
      if (stall && i % 3 == 2) begin
        repeat (5) begin
          b0.EN      = 1'b0;
          b0.IN      = 1'b1;
          b0.SIGN_IN = 1'b0;
          b0.START   = 1'b0;
          step();
        end
      end
      b0.EN      = 1'b1;
      b0.IN      = ins[i];
      b0.SIGN_IN = sg[i];
      b0.START   = (i == start_at);
      if (i == 15) q0.push_back('{v: 6'(ev), c: cyc + 1});
      step();
    end
    b0.EN    = 1'b0;
    b0.START = 1'b0;
  endtask
  initial begin
    init0 = 1'b1; init1 = 1'b1;
    b0.START = 1'b0; b0.EN = 1'b0; b0.IN = 1'b0; b0.SIGN_IN = 1'b0;
    b1.START = 1'b0; b1.EN = 1'b1; b1.IN = 1'b1; b1.SIGN_IN = 1'b0;
    fork
      begin
        repeat (3) step();
        chk("reset_busy", int'(b0.BUSY), 0);
        chk("reset_value", int'(b0.VALUE), 0);
        chk("reset_valid", int'(b0.VALID), 0);
        init0 = 1'b0;
        step();
        start_win();
        chk("busy_after_start", int'(b0.BUSY), 1);
        for (int i = 0; i < 8; i++) begin
          b0.EN = 1'b1; b0.IN = 1'b1; b0.SIGN_IN = 1'b0;
          step();
        end
        b0.EN = 1'b0;
        init0 = 1'b1;
        step();
        init0 = 1'b0;
        chk("abort_busy", int'(b0.BUSY), 0);
        chk("abort_value", int'(b0.VALUE), 0);
        chk("abort_valid", int'(b0.VALID), 0);
        repeat (3) step();
        chk("abort_stays_idle", int'(b0.BUSY), 0);
        start_win();
        win(16'hFFFF, 16'h0000, 16, 1'b0, -1);
        start_win();
        win(16'hFFFF, 16'hFFFF, -16, 1'b0, -1);
        start_win();
        win(16'h0FFF, 16'h0C00, 8, 1'b0, -1);
        start_win();
        win(16'h0000, 16'hAAAA, 0, 1'b0, -1);
        step();
        chk("value_holds", int'($signed(b0.VALUE)), 0);
        start_win();
        win(16'hFFFF, 16'h0000, 16, 1'b1, -1);
        start_win();
        win(16'hFFFF, 16'h0000, 16, 1'b0, 7);
        start_win();
        chk("busy_after_start_on_valid", int'(b0.BUSY), 1);
        win(16'hFFFF, 16'h000F, 8, 1'b0, -1);
        init0 = 1'b1;
        b0.START = 1'b1;
        step();
        init0 = 1'b0;
        b0.START = 1'b0;
        chk("init_beats_start", int'(b0.BUSY), 0);
        chk("init_clears_value", int'(b0.VALUE), 0);
        step();
        chk("idle_after_init_start", int'(b0.BUSY), 0);
      end
      begin
        repeat (2) step();
        chk("cont_reset_busy", int'(b1.BUSY), 0);
        init1 = 1'b0;
        for (int i = 0; i < 4; i++) q1.push_back('{v: 6'sd16, c: cyc + 17 + 16 * i});
        step();
        for (int i = 0; i < 64; i++) begin
          chk("cont_busy", int'(b1.BUSY), 1);
          step();
        end
        init1 = 1'b1;
        step();
        chk("cont_busy_after_init", int'(b1.BUSY), 0);
      end
    join
    repeat (20) step();
    chk("dut0_missing_valid", q0.size(), 0);
    chk("dut1_missing_valid", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ss_window_decoder.md
Name: ss_window_decoder

Overview:
- Downstream consumer of the sign-magnitude stochastic smoother. Takes its smoothed magnitude bit and sign bit and converts them back to a signed binary value.
- Integrates the stream over a window of 2^WIN_LOG2 enabled cycles with a signed up/down accumulator.
- Presents the result as a two's-complement word with a one-cycle valid strobe.
- Used at network outputs and for training-side readback.

Parameters:
- WIN_LOG2, default 8: log2 of the window length in enabled samples.
- CONTINUOUS, default 0: 1 = start a new window automatically after each result; 0 = wait for START.

Ports:
- CLK  input  1  clock; all logic on its rising edge.
- INIT  input  1  reset; synchronous, active-high.
- START  input  1  single-cycle request to begin a window; used only when CONTINUOUS=0.
- EN  input  1  sample qualifier; IN and SIGN_IN are consumed only when EN=1.
- IN  input  1  stochastic magnitude bit (smoother OUT).
- SIGN_IN  input  1  stochastic sign bit (smoother SIGN_OUT); 1 = negative.
- BUSY  output  1  high while a window is being accumulated.
- VALUE  output  WIN_LOG2+2  signed two's-complement result of the last completed window.
- VALID  output  1  single-cycle strobe, high on the cycle VALUE updates.

Behaviour:
- Reset: INIT=1 at a rising edge forces state IDLE, accumulator=0, sample counter=0, BUSY=0, VALUE=0, VALID=0. INIT overrides every other input and aborts any partial window; a partial window is never reported.
- States: IDLE, RUN.
  - IDLE -> RUN when START=1 (CONTINUOUS=0). With CONTINUOUS=1, the state goes to RUN on the first cycle after INIT deasserts.
  - RUN -> IDLE after the final sample (CONTINUOUS=0).
  - RUN -> RUN after the final sample (CONTINUOUS=1). The accumulator and counter reload with no gap cycle.
- BUSY = 1 exactly when the state is RUN (registered with the state).
- Entering RUN clears the accumulator and sample counter. The START cycle itself is not sampled; sampling begins on the next cycle.
- Per cycle in RUN with EN=1:
  - IN=1, SIGN_IN=0: accumulator +1.
  - IN=1, SIGN_IN=1: accumulator -1.
  - IN=0: accumulator unchanged, regardless of SIGN_IN.
  - In all three cases the sample counter increments.
- EN=0 in RUN: accumulator and sample counter hold; the window is stretched, not shortened.
- Final sample: the enabled cycle on which the sample counter equals 2^WIN_LOG2-1.
  - That sample is included in the result.
  - On the next rising edge, VALUE <= final accumulator and VALID=1 for that one cycle.
  - Latency from the final sample to VALID is 1 cycle.
- VALUE holds between windows and is never cleared except by INIT.
- Width rule: the accumulator is WIN_LOG2+2 bits signed. The range [-2^WIN_LOG2, +2^WIN_LOG2] fits exactly, so no saturation or overflow is possible.
- The sample counter is WIN_LOG2 bits and wraps naturally to 0 after the final sample.
- START while BUSY=1 is ignored. START is ignored when CONTINUOUS=1.
- START on the cycle VALID is asserted (CONTINUOUS=0): accepted, because the state is already IDLE at that point. The new window starts next cycle.
- START and INIT in the same cycle: INIT wins; the state stays IDLE.
- Decoded value = VALUE / 2^WIN_LOG2. The sign convention matches the smoother (SIGN=1 is negative).

Test Plan:
- Reset mid-window: WIN_LOG2=4, CONTINUOUS=0. START, then 8 enabled samples of IN=1/SIGN_IN=0, then INIT -> BUSY=0, VALUE=0, no VALID. A following START plus 16 samples of IN=1/SIGN_IN=0 -> VALUE=+16, VALID one cycle after the 16th sample, BUSY=0 on the same cycle.
- Negative full scale and mixed input: 16 samples of IN=1/SIGN_IN=1 -> VALUE=-16 (6'b110000). Then 10 samples IN=1/SIGN_IN=0, 2 samples IN=1/SIGN_IN=1, 4 samples IN=0 -> VALUE=+8.
- Zero-magnitude sign noise: 16 samples of IN=0 with SIGN_IN toggling every cycle -> VALUE=0, VALID=1.
- EN stall: 16 samples of IN=1/SIGN_IN=0, with EN low for 5 cycles every 3rd sample -> VALID arrives 16 enabled samples after START (not 16 cycles), VALUE=+16.
- START handling: START pulsed while BUSY -> no effect on window length or VALUE. START on the VALID cycle -> BUSY=1 next cycle, and a second VALID 17 cycles later with EN held high.
- CONTINUOUS=1: after INIT release, constant IN=1/SIGN_IN=0 with EN=1 -> VALID every 16 cycles, VALUE=+16 each time, BUSY never drops.
